// File: rtl/ir_pkg.sv
// ----------------------------------------------------------------------------
// ir_pkg
// Shared types and constants for the instruction fetch path and the IR.
//   fetch_state_t : fetch sequencer states
//   HALT_OP_DEF   : default opcode that stops fetching
//   OPC/RA/RB/RC  : bit positions of the four 4-bit instruction fields
//   get_opcode()  : extracts the opcode field of a 16-bit word
// ----------------------------------------------------------------------------
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    LOAD = 3'd3,
    EXEC = 3'd4,
    HALT = 3'd5
  } fetch_state_t;

  localparam logic [3:0] HALT_OP_DEF = 4'hF;

  // Instruction field slices, shared with the instruction register.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 4;
  localparam int RC_MSB  = 3;
  localparam int RC_LSB  = 0;

  function automatic logic [3:0] get_opcode(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// ----------------------------------------------------------------------------
// fetch_pc
// Program-counter register for the fetch sequencer.
//   clk, rst      : clock, asynchronous active-low reset (pc -> 0)
//   i_inc         : advance pc by one, wrapping modulo 2^PC_W
//   i_load        : load pc from i_load_addr (takes priority over i_inc)
//   i_load_addr   : branch target
//   o_pc          : registered program counter
//   o_pc_nxt      : value pc takes at the next edge (used for the read address
//                   so a branch target is issued in the same cycle it loads)
// ----------------------------------------------------------------------------
module fetch_pc #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_inc,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_load_addr,
  output logic [PC_W-1:0] o_pc,
  output logic [PC_W-1:0] o_pc_nxt
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;

  // Next-pc selection: branch load, increment with natural wrap, or hold.
  always_comb begin
    w_pc_nxt = r_pc;
    if (i_load) begin
      w_pc_nxt = i_load_addr;
    end else if (i_inc) begin
      w_pc_nxt = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Program-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= {PC_W{1'b0}};
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc     = r_pc;
  assign o_pc_nxt = w_pc_nxt;

endmodule

// File: rtl/ir_fetch.sv
// ----------------------------------------------------------------------------
// ir_fetch
// Instruction fetch sequencer. Issues one read at a time to instruction memory,
// presents the returned word on din with a one-cycle writeC strobe for the IR,
// then waits for the control unit (next) before fetching again.
//   clk, rst               : clock, asynchronous active-low reset
//   start                  : begin/resume fetching (IDLE or HALT only)
//   next, branch_en        : fetch next word, optionally from branch_addr
//   branch_addr            : branch target
//   imem_rd, imem_addr     : one-cycle read request and its address
//   imem_rdata, imem_valid : read data and its valid pulse (sampled in WAIT)
//   din, writeC            : instruction word and IR load strobe
//   pc                     : address of the next word to fetch
//   busy, halted           : status (REQ/WAIT/LOAD, HALT)
// All outputs are registered: each is computed from the next state so it is
// valid in the same cycle the FSM occupies that state.
// ----------------------------------------------------------------------------
module ir_fetch
  import ir_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter int         DATA_W  = 16,
  parameter logic [3:0] HALT_OP = HALT_OP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              next,
  input  logic              branch_en,
  input  logic [PC_W-1:0]   branch_addr,
  output logic              imem_rd,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [DATA_W-1:0] din,
  output logic              writeC,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              w_pc_inc;
  logic              w_pc_load;
  logic [PC_W-1:0]   w_pc_nxt;
  logic              r_imem_rd;
  logic [PC_W-1:0]   r_imem_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_writec;
  logic              r_busy;
  logic              r_halted;

  fetch_pc #(
    .PC_W (PC_W)
  ) u_fetch_pc (
    .clk         (clk),
    .rst         (rst),
    .i_inc       (w_pc_inc),
    .i_load      (w_pc_load),
    .i_load_addr (branch_addr),
    .o_pc        (pc),
    .o_pc_nxt    (w_pc_nxt)
  );

  // Next-state and pc-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_inc    = 1'b0;
    w_pc_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = REQ;
        else       w_state_nxt = IDLE;
      end
      REQ: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_valid) w_state_nxt = LOAD;
        else            w_state_nxt = WAIT;
      end
      LOAD: begin
        w_pc_inc = 1'b1;
        // r_din already holds the word being loaded.
        if (r_din[OPC_MSB:OPC_LSB] == HALT_OP) w_state_nxt = HALT;
        else                                   w_state_nxt = EXEC;
      end
      EXEC: begin
        if (next) begin
          w_state_nxt = REQ;
          w_pc_load   = branch_en;
        end else begin
          w_state_nxt = EXEC;
        end
      end
      HALT: begin
        if (start) w_state_nxt = REQ;
        else       w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_imem_rd   <= 1'b0;
      r_imem_addr <= {PC_W{1'b0}};
      r_din       <= {DATA_W{1'b0}};
      r_writec    <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_imem_rd <= (w_state_nxt == REQ);
      // w_pc_nxt already reflects a branch taken on this edge.
      if (w_state_nxt == REQ) begin
        r_imem_addr <= w_pc_nxt;
      end else begin
        r_imem_addr <= r_imem_addr;
      end
      if ((r_state == WAIT) && imem_valid) begin
        r_din <= imem_rdata;
      end else begin
        r_din <= r_din;
      end
      r_writec <= (w_state_nxt == LOAD);
      r_busy   <= (w_state_nxt == REQ) || (w_state_nxt == WAIT) ||
                  (w_state_nxt == LOAD);
      r_halted <= (w_state_nxt == HALT);
    end
  end

  assign imem_rd   = r_imem_rd;
  assign imem_addr = r_imem_addr;
  assign din       = r_din;
  assign writeC    = r_writec;
  assign busy      = r_busy;
  assign halted    = r_halted;

endmodule

// File: tb/tb_ir_fetch.sv
// ----------------------------------------------------------------------------
// tb_ir_fetch
// Directed bench for ir_fetch with a behavioural instruction memory of
// programmable latency.
// ----------------------------------------------------------------------------
module tb_ir_fetch;
  import ir_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        next;
  logic        branch_en;
  logic [7:0]  branch_addr;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_valid = 1'b0;
  logic [15:0] din;
  logic        writeC;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;

  logic [15:0] mem [0:255];
  int          lat = 1;
  int          cnt = 0;
  logic [7:0]  addr_l = 8'h00;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  logic        seen_wc;
  logic        seen_rd;
  logic        seen_valid;

  always #5 clk = ~clk;

  ir_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .next        (next),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .din         (din),
    .writeC      (writeC),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  // Memory model: a read seen in cycle k returns valid data in cycle k+lat.
  always @(posedge clk) begin
    imem_valid <= 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_valid <= 1'b1;
        imem_rdata <= mem[addr_l];
      end
    end
    if (imem_rd) begin
      addr_l = imem_addr;
      if (lat <= 1) begin
        cnt = 0;
        imem_valid <= 1'b1;
        imem_rdata <= mem[imem_addr];
      end else begin
        cnt = lat - 1;
      end
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call right after the edge that sampled start/next (cycle 1); returns the
  // cycle number in which writeC was first seen high.
  task automatic wait_wc(output int c);
    c = 1;
    while (!writeC && c < 40) begin
      tick();
      c++;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_vec({tag, "_pc"},     {24'h0, pc},        32'h0);
    check_vec({tag, "_rd"},     {31'h0, imem_rd},   32'h0);
    check_vec({tag, "_addr"},   {24'h0, imem_addr}, 32'h0);
    check_vec({tag, "_din"},    {16'h0, din},       32'h0);
    check_vec({tag, "_wc"},     {31'h0, writeC},    32'h0);
    check_vec({tag, "_busy"},   {31'h0, busy},      32'h0);
    check_vec({tag, "_halted"}, {31'h0, halted},    32'h0);
    check_vec({tag, "_state"},  {29'h0, dut.r_state}, {29'h0, IDLE});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h3001;
    mem[8'h02] = 16'hF000;
    mem[8'h03] = 16'h5005;
    mem[8'h40] = 16'h6040;
    mem[8'hFF] = 16'h2000;

    rst = 1'b0; start = 1'b0; next = 1'b0;
    branch_en = 1'b0; branch_addr = 8'h00;
    tick(); tick(); tick();
    check_reset_outs("rst");
    rst = 1'b1;
    tick();

    // First fetch, L=1: rd in cycle 1, writeC in cycle 3.
    start = 1'b1; tick(); start = 1'b0;
    check_vec("f0_rd",   {31'h0, imem_rd},   32'h1);
    check_vec("f0_addr", {24'h0, imem_addr}, 32'h0);
    check_vec("f0_busy", {31'h0, busy},      32'h1);
    tick();
    check_vec("f0_wc_c2", {31'h0, writeC}, 32'h0);
    tick();
    check_vec("f0_wc_c3", {31'h0, writeC}, 32'h1);
    check_vec("f0_din",   {16'h0, din},    32'h1234);
    check_vec("f0_pc_ld", {24'h0, pc},     32'h0);
    tick();
    check_vec("f0_wc_c4", {31'h0, writeC}, 32'h0);
    check_vec("f0_pc",    {24'h0, pc},     32'h1);
    check_vec("f0_state", {29'h0, dut.r_state}, {29'h0, EXEC});
    check_vec("f0_busy2", {31'h0, busy},   32'h0);

    // next with L=4: writeC 6 cycles after next.
    lat = 4;
    next = 1'b1; tick(); next = 1'b0;
    check_vec("f1_din_hold", {16'h0, din},       32'h1234);
    check_vec("f1_addr",     {24'h0, imem_addr}, 32'h1);
    wait_wc(cyc);
    check_vec("f1_lat", cyc, 32'd6);
    check_vec("f1_din", {16'h0, din}, 32'h3001);
    tick();
    check_vec("f1_wc_once", {31'h0, writeC}, 32'h0);
    check_vec("f1_pc",      {24'h0, pc},     32'h2);

    // Halt word.
    next = 1'b1; tick(); next = 1'b0;
    wait_wc(cyc);
    check_vec("f2_lat", cyc, 32'd6);
    check_vec("f2_din", {16'h0, din}, 32'hF000);
    tick();
    check_vec("f2_wc_once", {31'h0, writeC}, 32'h0);
    check_vec("f2_halted",  {31'h0, halted}, 32'h1);
    check_vec("f2_pc",      {24'h0, pc},     32'h3);
    seen_rd = 1'b0;
    next = 1'b1; tick(); next = 1'b0;
    seen_rd = seen_rd | imem_rd;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_rd = seen_rd | imem_rd;
    end
    check_vec("halt_next_ign", {31'h0, halted},  32'h1);
    check_vec("halt_no_rd",    {31'h0, seen_rd}, 32'h0);
    check_vec("halt_pc",       {24'h0, pc},      32'h3);

    // Resume from HALT at the word after the halt.
    lat = 1;
    start = 1'b1; tick(); start = 1'b0;
    check_vec("res_rd",   {31'h0, imem_rd},   32'h1);
    check_vec("res_addr", {24'h0, imem_addr}, 32'h3);
    check_vec("res_halted", {31'h0, halted},  32'h0);
    wait_wc(cyc);
    check_vec("res_lat", cyc, 32'd3);
    check_vec("res_din", {16'h0, din}, 32'h5005);
    tick();
    check_vec("res_pc", {24'h0, pc}, 32'h4);

    // branch_en without next does nothing.
    branch_en = 1'b1; branch_addr = 8'h77;
    tick(); tick();
    check_vec("br_nonext_pc", {24'h0, pc},      32'h4);
    check_vec("br_nonext_rd", {31'h0, imem_rd}, 32'h0);

    // Branch to 0x40.
    branch_addr = 8'h40; next = 1'b1; tick();
    next = 1'b0; branch_en = 1'b0;
    check_vec("br_rd",   {31'h0, imem_rd},   32'h1);
    check_vec("br_addr", {24'h0, imem_addr}, 32'h40);
    wait_wc(cyc);
    check_vec("br_lat", cyc, 32'd3);
    check_vec("br_din", {16'h0, din}, 32'h6040);
    tick();
    check_vec("br_pc", {24'h0, pc}, 32'h41);

    // Fetch from 0xFF: pc wraps to 0.
    branch_en = 1'b1; branch_addr = 8'hFF; next = 1'b1; tick();
    next = 1'b0; branch_en = 1'b0;
    check_vec("wr_addr", {24'h0, imem_addr}, 32'hFF);
    wait_wc(cyc);
    check_vec("wr_din",   {16'h0, din}, 32'h2000);
    check_vec("wr_pc_ld", {24'h0, pc},  32'hFF);
    tick();
    check_vec("wr_pc",    {24'h0, pc},  32'h0);
    check_vec("wr_state", {29'h0, dut.r_state}, {29'h0, EXEC});

    // Reset during WAIT with the read still in flight.
    lat = 4;
    next = 1'b1; tick(); next = 1'b0;
    tick(); tick();
    check_vec("mid_state", {29'h0, dut.r_state}, {29'h0, WAIT});
    rst = 1'b0;
    #1;
    check_reset_outs("mid_async");
    tick();
    rst = 1'b1;
    seen_wc = 1'b0; seen_rd = 1'b0; seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_wc    = seen_wc | writeC;
      seen_rd    = seen_rd | imem_rd;
      seen_valid = seen_valid | imem_valid;
    end
    check_vec("post_valid_seen", {31'h0, seen_valid}, 32'h1);
    check_vec("post_no_wc",      {31'h0, seen_wc},    32'h0);
    check_vec("post_no_rd",      {31'h0, seen_rd},    32'h0);
    check_reset_outs("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ir_fetch.md
# ir_fetch

Instruction fetch sequencer that produces the instruction stream consumed by the instruction register. It owns the program counter and issues reads to instruction memory through a request/valid handshake. It presents each returned 16-bit word with a one-cycle `writeC` strobe so the IR latches it, then holds until the control unit requests the next instruction.

## Interface
Parameters:
- `PC_W`, 8, program-counter and instruction-memory address width
- `DATA_W`, 16, instruction word width
- `HALT_OP`, 4'hF, opcode (word bits [15:12]) that stops fetching

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous reset, active-low; asserted at 0
- `start`  in  1  begin or resume fetching from the current `pc`
- `next`  in  1  control unit is done with the current instruction; fetch the next one
- `branch_en`  in  1  qualifies `next`: load `pc` from `branch_addr` instead of keeping pc+1
- `branch_addr`  in  PC_W  branch target
- `imem_rd`  out  1  one-cycle read request
- `imem_addr`  out  PC_W  read address, valid while `imem_rd`=1
- `imem_rdata`  in  DATA_W  read data, valid while `imem_valid`=1
- `imem_valid`  in  1  read-data-valid pulse, latency ≥1 cycle after `imem_rd`
- `din`  out  DATA_W  instruction word to the IR
- `writeC`  out  1  IR load strobe, exactly one cycle per fetched word
- `pc`  out  PC_W  address of the next word to fetch
- `busy`  out  1  high in REQ, WAIT and LOAD
- `halted`  out  1  high in HALT

## Operation
- All outputs are registered. Reset values: `pc`=0, `imem_rd`=0, `imem_addr`=0, `din`=0, `writeC`=0, `busy`=0, `halted`=0, state=IDLE.
- IDLE: `start`=1 -> REQ. Other inputs are ignored.
- REQ (1 cycle): drive `imem_rd`=1 and `imem_addr`=`pc`. Next state is WAIT.
- WAIT: `imem_valid` is sampled only in this state. A valid pulse in any other state is dropped.
  - On `imem_valid`=1: capture `imem_rdata` into `din`, then go to LOAD.
  - Otherwise stay in WAIT; there is no timeout.
- LOAD (1 cycle): `writeC`=1, with `din` stable. `pc` <= `pc`+1, modulo 2^PC_W, so all-ones wraps to 0.
  - If `din[15:12]`==`HALT_OP`: go to HALT.
  - Otherwise go to EXEC.
- EXEC: wait for `next`=1.
  - With `branch_en`=1, `pc` <= `branch_addr`.
  - Go to REQ.
  - `branch_en` without `next` has no effect.
- HALT: `halted`=1. `start`=1 -> REQ, resuming at `pc`, which is the word after the halt. `next` is ignored.
- `din` holds its last captured value until the next capture; it is not cleared between fetches.
- `start` in any state other than IDLE or HALT is ignored.
- `next` outside EXEC is ignored.
- Reset asserted mid-fetch aborts immediately: all outputs return to their reset values and any in-flight `imem_valid` is dropped.

## Timing
- Latency `start` -> `writeC` = 2 + L cycles, where L ≥ 1 is memory latency. With L=1, `start` is sampled at edge 0, `imem_rd` is high in cycle 1, `imem_valid` arrives in cycle 2, and `writeC` is high in cycle 3.
- Latency `next` -> `writeC` = 2 + L cycles.
- `pc` is updated at the end of the LOAD cycle. During the `writeC` cycle, `pc` still shows the address of the word being loaded.
- There is exactly one outstanding memory read at any time.

## Structure
- Package `ir_pkg`:
  - state enum `fetch_state_t` {IDLE, REQ, WAIT, LOAD, EXEC, HALT}
  - `HALT_OP` default
  - the opcode field slice constants [15:12], [11:8], [7:4], [3:0], shared with the IR
- Sub-module `fetch_pc`, the program-counter register:
  - increment and wrap
  - branch load
  - reset to 0
- `ir_fetch` itself holds the FSM and the output registers.

## Test plan
- Reset, then `start` with L=1 and mem[0]=16'h1234 -> `imem_rd` with addr 0 in cycle 1; `writeC` pulse in cycle 3 with `din`=16'h1234; `pc`=1 afterwards; state EXEC.
- L=4 and `next` pulses -> each `writeC` arrives 6 cycles after its `next`; `writeC` is never high for 2 consecutive cycles.
- `next` with `branch_en`=1 and `branch_addr`=8'h40 -> next `imem_addr`=8'h40; `pc`=8'h41 after that LOAD.
- mem[8'hFF]=16'h2000 fetched from pc=8'hFF -> `pc` wraps to 0.
- mem[2]=16'hF000 -> `halted`=1 after LOAD and `next` is ignored; `start` -> fetch resumes at address 3.
- Reset asserted during WAIT, with `imem_valid` arriving afterwards -> all outputs are at reset values, no `writeC`, state IDLE.
